vend_fsm_param: RTL and testbench

- Parametrised successor to the fixed-price 25c vending controller.
- Accumulates credit in nickel units from a validated coin stream, vends one product when credit reaches PRICE, then returns change one coin at a time over a valid/ack handshake.
- Adds cancel/refund, coin rejection and an overflow guard; price and credit width are set at instantiation.
- Sits between the coin acceptor front end and the product and change dispensers.

---
 rtl/vend_fsm_param.sv | 163 ++++++++++++++++
 tb/tb_vend_fsm_param.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_fsm_param.sv
// ----------------------------------------------------------------------------
// vend_fsm_param
// Parametrised vending controller. Credit is accumulated in nickel units from
// a validated coin stream. One product is vended when credit reaches PRICE,
// and any remainder (or a cancelled credit) is paid back one coin at a time
// over a valid/ack handshake. Illegal coin codes, coins that would overflow
// MAX_CREDIT and coins arriving while busy are bounced back via coin_reject.
//
// Ports
//   clock        in   system clock, rising edge
//   reset        in   asynchronous, active-high reset
//   coin_valid   in   one-cycle strobe, coin_type valid this cycle
//   coin_type    in   00 nickel, 01 dime, 10 quarter, 11 invalid
//   cancel       in   one-cycle refund request (honoured in COLLECT only)
//   chg_ack      in   change dispenser took the coin offered on chg_coin
//   vend         out  one-cycle product dispense pulse
//   coin_reject  out  one-cycle pulse, previous-cycle coin was returned
//   chg_valid    out  a change coin is offered on chg_coin
//   chg_coin     out  00 nickel, 01 dime
//   credit       out  current credit in nickel units
//   state        out  00 IDLE, 01 COLLECT, 10 VEND, 11 CHANGE
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no credit held, waiting for the first coin
// COLLECT | partial credit held, waiting for more coins or a cancel
// VEND    | single cycle, product dispensed, price deducted on exit
// CHANGE  | paying back credit greedily (dimes first) over valid/ack
// ----------------------------------------------------------------------------
module vend_fsm_param #(
    parameter int PRICE      = 5,
    parameter int MAX_CREDIT = 9,
    parameter int CREDIT_W   = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                coin_valid,
    input  logic [1:0]          coin_type,
    input  logic                cancel,
    input  logic                chg_ack,
    output logic                vend,
    output logic                coin_reject,
    output logic                chg_valid,
    output logic [1:0]          chg_coin,
    output logic [CREDIT_W-1:0] credit,
    output logic [1:0]          state
);

    localparam logic [1:0] S_IDLE    = 2'b00;
    localparam logic [1:0] S_COLLECT = 2'b01;
    localparam logic [1:0] S_VEND    = 2'b10;
    localparam logic [1:0] S_CHANGE  = 2'b11;

    localparam logic [1:0] COIN_NICKEL = 2'b00;
    localparam logic [1:0] COIN_DIME   = 2'b01;

    // Sum-side constants carry one extra bit so the overflow compare never wraps.
    localparam logic [CREDIT_W:0]   PRICE_X = (CREDIT_W+1)'(PRICE);
    localparam logic [CREDIT_W:0]   MAX_X   = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] PRICE_N = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] ONE_N   = CREDIT_W'(1);
    localparam logic [CREDIT_W-1:0] TWO_N   = CREDIT_W'(2);
    localparam logic [CREDIT_W-1:0] ZERO_N  = '0;

    logic [1:0]          state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                vend_q, vend_d;
    logic                reject_q, reject_d;
    logic                chg_valid_q, chg_valid_d;
    logic [1:0]          chg_coin_q, chg_coin_d;

    logic [CREDIT_W:0]   coin_val;
    logic [CREDIT_W:0]   sum;
    logic                coin_ok;
    logic [CREDIT_W-1:0] chg_dec;

    always_comb begin
        coin_val = '0;
        case (coin_type)
            2'b00:   coin_val = (CREDIT_W+1)'(1);
            2'b01:   coin_val = (CREDIT_W+1)'(2);
            2'b10:   coin_val = (CREDIT_W+1)'(5);
            default: coin_val = '0;
        endcase
    end

    assign sum     = {1'b0, credit_q} + coin_val;
    assign coin_ok = coin_valid && (coin_type != 2'b11) && (sum <= MAX_X);
    assign chg_dec = (chg_coin_q == COIN_DIME) ? TWO_N : ONE_N;

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        reject_d = 1'b0;
        case (state_q)
            S_IDLE, S_COLLECT: begin
                // Cancel beats a simultaneous coin; IDLE ignores cancel entirely.
                if (state_q == S_COLLECT && cancel) begin
                    reject_d = coin_valid;
                    state_d  = (credit_q == ZERO_N) ? S_IDLE : S_CHANGE;
                end else if (coin_valid) begin
                    if (coin_ok) begin
                        credit_d = sum[CREDIT_W-1:0];
                        state_d  = (sum >= PRICE_X) ? S_VEND : S_COLLECT;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            S_VEND: begin
                reject_d = coin_valid;
                credit_d = credit_q - PRICE_N;
                state_d  = (credit_q == PRICE_N) ? S_IDLE : S_CHANGE;
            end
            S_CHANGE: begin
                reject_d = coin_valid;
                if (chg_valid_q && chg_ack) begin
                    credit_d = credit_q - chg_dec;
                    state_d  = (credit_q == chg_dec) ? S_IDLE : S_CHANGE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state values so they line up with state.
    always_comb begin
        vend_d      = (state_d == S_VEND);
        chg_valid_d = (state_d == S_CHANGE);
        chg_coin_d  = COIN_NICKEL;
        if (state_d == S_CHANGE && credit_d >= TWO_N) begin
            chg_coin_d = COIN_DIME;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            credit_q    <= '0;
            vend_q      <= 1'b0;
            reject_q    <= 1'b0;
            chg_valid_q <= 1'b0;
            chg_coin_q  <= COIN_NICKEL;
        end else begin
            state_q     <= state_d;
            credit_q    <= credit_d;
            vend_q      <= vend_d;
            reject_q    <= reject_d;
            chg_valid_q <= chg_valid_d;
            chg_coin_q  <= chg_coin_d;
        end
    end

    assign state       = state_q;
    assign credit      = credit_q;
    assign vend        = vend_q;
    assign coin_reject = reject_q;
    assign chg_valid   = chg_valid_q;
    assign chg_coin    = chg_coin_q;

endmodule

// File: tb/tb_vend_fsm_param.sv
module tb_vend_fsm_param;

    logic       clock = 1'b0;
    logic       reset = 1'b1;

    // Default-parameter instance (PRICE 5, MAX_CREDIT 9)
    logic       coin_valid = 1'b0;
    logic [1:0] coin_type  = 2'b00;
    logic       cancel     = 1'b0;
    logic       chg_ack    = 1'b0;
    logic       vend, coin_reject, chg_valid;
    logic [1:0] chg_coin, state;
    logic [3:0] credit;

    // Tight instance (PRICE 6, MAX_CREDIT 6, 3-bit credit)
    logic       b_coin_valid = 1'b0;
    logic [1:0] b_coin_type  = 2'b00;
    logic       b_cancel     = 1'b0;
    logic       b_chg_ack    = 1'b0;
    logic       b_vend, b_coin_reject, b_chg_valid;
    logic [1:0] b_chg_coin, b_state;
    logic [2:0] b_credit;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    vend_fsm_param dut (
        .clock(clock), .reset(reset),
        .coin_valid(coin_valid), .coin_type(coin_type),
        .cancel(cancel), .chg_ack(chg_ack),
        .vend(vend), .coin_reject(coin_reject),
        .chg_valid(chg_valid), .chg_coin(chg_coin),
        .credit(credit), .state(state)
    );

    vend_fsm_param #(.PRICE(6), .MAX_CREDIT(6), .CREDIT_W(3)) dut_b (
        .clock(clock), .reset(reset),
        .coin_valid(b_coin_valid), .coin_type(b_coin_type),
        .cancel(b_cancel), .chg_ack(b_chg_ack),
        .vend(b_vend), .coin_reject(b_coin_reject),
        .chg_valid(b_chg_valid), .chg_coin(b_chg_coin),
        .credit(b_credit), .state(b_state)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic coin(input logic [1:0] t);
        coin_valid = 1'b1;
        coin_type  = t;
        tick();
        coin_valid = 1'b0;
    endtask

    task automatic b_coin(input logic [1:0] t);
        b_coin_valid = 1'b1;
        b_coin_type  = t;
        tick();
        b_coin_valid = 1'b0;
    endtask

    task automatic ack();
        chg_ack = 1'b1;
        tick();
        chg_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        tick();
        checks++;
        if ({state, credit, vend, coin_reject, chg_valid, chg_coin} !== 11'b0) begin
            errors++;
            $display("FAIL reset_a got st=%b cr=%0d v=%b rj=%b cv=%b cc=%b want all zero",
                     state, credit, vend, coin_reject, chg_valid, chg_coin);
        end
        checks++;
        if ({b_state, b_credit, b_vend, b_coin_reject, b_chg_valid, b_chg_coin} !== 10'b0) begin
            errors++;
            $display("FAIL reset_b got st=%b cr=%0d want all zero", b_state, b_credit);
        end
    endtask

    task automatic test_dime_vend();
        coin(2'b01);
        checks++;
        if (credit !== 4'd2 || state !== 2'b01 || coin_reject !== 1'b0) begin
            errors++;
            $display("FAIL dime1 got cr=%0d st=%b rj=%b want cr=2 st=01 rj=0", credit, state, coin_reject);
        end
        coin(2'b01);
        checks++;
        if (credit !== 4'd4 || state !== 2'b01 || coin_reject !== 1'b0) begin
            errors++;
            $display("FAIL dime2 got cr=%0d st=%b rj=%b want cr=4 st=01 rj=0", credit, state, coin_reject);
        end
        coin(2'b01);
        checks++;
        if (credit !== 4'd6 || state !== 2'b10 || vend !== 1'b1 || chg_valid !== 1'b0) begin
            errors++;
            $display("FAIL dime3_vend got cr=%0d st=%b v=%b cv=%b want cr=6 st=10 v=1 cv=0",
                     credit, state, vend, chg_valid);
        end
        tick();
        checks++;
        if (credit !== 4'd1 || state !== 2'b11 || vend !== 1'b0 || chg_valid !== 1'b1 || chg_coin !== 2'b00) begin
            errors++;
            $display("FAIL dime_change got cr=%0d st=%b v=%b cv=%b cc=%b want cr=1 st=11 v=0 cv=1 cc=00",
                     credit, state, vend, chg_valid, chg_coin);
        end
        ack();
        checks++;
        if (credit !== 4'd0 || state !== 2'b00 || chg_valid !== 1'b0) begin
            errors++;
            $display("FAIL dime_done got cr=%0d st=%b cv=%b want cr=0 st=00 cv=0", credit, state, chg_valid);
        end
    endtask

    task automatic test_quarter();
        coin(2'b10);
        checks++;
        if (state !== 2'b10 || vend !== 1'b1 || chg_valid !== 1'b0) begin
            errors++;
            $display("FAIL quarter_vend got st=%b v=%b cv=%b want st=10 v=1 cv=0", state, vend, chg_valid);
        end
        tick();
        checks++;
        if (state !== 2'b00 || credit !== 4'd0 || vend !== 1'b0 || chg_valid !== 1'b0) begin
            errors++;
            $display("FAIL quarter_idle got st=%b cr=%0d v=%b cv=%b want st=00 cr=0 v=0 cv=0",
                     state, credit, vend, chg_valid);
        end
    endtask

    task automatic test_cancel();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        checks++;
        if (state !== 2'b00 || chg_valid !== 1'b0) begin
            errors++;
            $display("FAIL cancel_idle got st=%b cv=%b want st=00 cv=0", state, chg_valid);
        end
        coin(2'b00);
        coin(2'b01);
        checks++;
        if (credit !== 4'd3 || state !== 2'b01) begin
            errors++;
            $display("FAIL cancel_credit got cr=%0d st=%b want cr=3 st=01", credit, state);
        end
        // cancel with a simultaneous coin: cancel wins, coin bounced
        cancel     = 1'b1;
        coin_valid = 1'b1;
        coin_type  = 2'b00;
        tick();
        cancel     = 1'b0;
        coin_valid = 1'b0;
        checks++;
        if (state !== 2'b11 || credit !== 4'd3 || chg_valid !== 1'b1 || chg_coin !== 2'b01 || coin_reject !== 1'b1) begin
            errors++;
            $display("FAIL cancel_change got st=%b cr=%0d cv=%b cc=%b rj=%b want st=11 cr=3 cv=1 cc=01 rj=1",
                     state, credit, chg_valid, chg_coin, coin_reject);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (chg_valid !== 1'b1 || chg_coin !== 2'b01 || credit !== 4'd3 || vend !== 1'b0) begin
                errors++;
                $display("FAIL cancel_hold%0d got cv=%b cc=%b cr=%0d v=%b want cv=1 cc=01 cr=3 v=0",
                         i, chg_valid, chg_coin, credit, vend);
            end
        end
        ack();
        checks++;
        if (credit !== 4'd1 || state !== 2'b11 || chg_valid !== 1'b1 || chg_coin !== 2'b00) begin
            errors++;
            $display("FAIL cancel_ack1 got cr=%0d st=%b cv=%b cc=%b want cr=1 st=11 cv=1 cc=00",
                     credit, state, chg_valid, chg_coin);
        end
        ack();
        checks++;
        if (credit !== 4'd0 || state !== 2'b00 || chg_valid !== 1'b0 || vend !== 1'b0) begin
            errors++;
            $display("FAIL cancel_ack2 got cr=%0d st=%b cv=%b v=%b want cr=0 st=00 cv=0 v=0",
                     credit, state, chg_valid, vend);
        end
    endtask

    task automatic test_overflow();
        b_coin(2'b01);
        b_coin(2'b01);
        checks++;
        if (b_credit !== 3'd4 || b_state !== 2'b01) begin
            errors++;
            $display("FAIL ovf_credit got cr=%0d st=%b want cr=4 st=01", b_credit, b_state);
        end
        b_coin(2'b10);
        checks++;
        if (b_credit !== 3'd4 || b_coin_reject !== 1'b1 || b_state !== 2'b01) begin
            errors++;
            $display("FAIL ovf_quarter got cr=%0d rj=%b st=%b want cr=4 rj=1 st=01", b_credit, b_coin_reject, b_state);
        end
        b_coin(2'b11);
        checks++;
        if (b_credit !== 3'd4 || b_coin_reject !== 1'b1) begin
            errors++;
            $display("FAIL ovf_invalid got cr=%0d rj=%b want cr=4 rj=1", b_credit, b_coin_reject);
        end
        b_coin(2'b01);
        checks++;
        if (b_credit !== 3'd6 || b_state !== 2'b10 || b_vend !== 1'b1 || b_coin_reject !== 1'b0) begin
            errors++;
            $display("FAIL ovf_vend got cr=%0d st=%b v=%b rj=%b want cr=6 st=10 v=1 rj=0",
                     b_credit, b_state, b_vend, b_coin_reject);
        end
        tick();
        checks++;
        if (b_credit !== 3'd0 || b_state !== 2'b00 || b_chg_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovf_idle got cr=%0d st=%b cv=%b want cr=0 st=00 cv=0", b_credit, b_state, b_chg_valid);
        end
    endtask

    task automatic test_busy_reject();
        coin(2'b00);
        coin(2'b01);
        coin(2'b10);
        checks++;
        if (credit !== 4'd8 || state !== 2'b10) begin
            errors++;
            $display("FAIL busy_vend got cr=%0d st=%b want cr=8 st=10", credit, state);
        end
        coin(2'b00);
        checks++;
        if (coin_reject !== 1'b1 || credit !== 4'd3 || state !== 2'b11 || chg_coin !== 2'b01) begin
            errors++;
            $display("FAIL busy_in_vend got rj=%b cr=%0d st=%b cc=%b want rj=1 cr=3 st=11 cc=01",
                     coin_reject, credit, state, chg_coin);
        end
        coin(2'b00);
        checks++;
        if (coin_reject !== 1'b1 || credit !== 4'd3 || state !== 2'b11) begin
            errors++;
            $display("FAIL busy_in_change got rj=%b cr=%0d st=%b want rj=1 cr=3 st=11", coin_reject, credit, state);
        end
        ack();
        checks++;
        if (coin_reject !== 1'b0 || credit !== 4'd1 || chg_coin !== 2'b00 || chg_valid !== 1'b1) begin
            errors++;
            $display("FAIL busy_ack1 got rj=%b cr=%0d cc=%b cv=%b want rj=0 cr=1 cc=00 cv=1",
                     coin_reject, credit, chg_coin, chg_valid);
        end
        ack();
        checks++;
        if (credit !== 4'd0 || state !== 2'b00 || chg_valid !== 1'b0) begin
            errors++;
            $display("FAIL busy_ack2 got cr=%0d st=%b cv=%b want cr=0 st=00 cv=0", credit, state, chg_valid);
        end
    endtask

    task automatic test_reset_mid_change();
        coin(2'b01);
        coin(2'b01);
        coin(2'b01);
        tick();
        checks++;
        if (state !== 2'b11 || chg_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_setup got st=%b cv=%b want st=11 cv=1", state, chg_valid);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({state, credit, vend, coin_reject, chg_valid, chg_coin} !== 11'b0) begin
            errors++;
            $display("FAIL rst_async got st=%b cr=%0d cv=%b want all zero", state, credit, chg_valid);
        end
        @(negedge clock);
        reset = 1'b0;
        tick();
        checks++;
        if (state !== 2'b00 || credit !== 4'd0) begin
            errors++;
            $display("FAIL rst_after got st=%b cr=%0d want st=00 cr=0", state, credit);
        end
        coin(2'b10);
        checks++;
        if (state !== 2'b10 || vend !== 1'b1) begin
            errors++;
            $display("FAIL rst_quarter got st=%b v=%b want st=10 v=1", state, vend);
        end
        tick();
        checks++;
        if (state !== 2'b00 || credit !== 4'd0 || vend !== 1'b0) begin
            errors++;
            $display("FAIL rst_quarter_idle got st=%b cr=%0d v=%b want st=00 cr=0 v=0", state, credit, vend);
        end
    endtask

    initial begin
        test_reset();
        test_dime_vend();
        test_quarter();
        test_cancel();
        test_overflow();
        test_busy_reject();
        test_reset_mid_change();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net so the run always ends even if stimulus stalls.
    initial begin
        #20000;
        $display("FAIL timeout reached without finishing");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
